// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master bridging a simple core request/response port.
// Define AXI_MASTER_ALIGN_CHECK_EN to reject misaligned addresses without bus activity.
module axi_lite_master #(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   // core request
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   input  logic [3:0]            req_wstrb,
   // core response
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   // AXI read
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic [2:0]            arprot,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic [31:0]           rdata,
   input  logic [1:0]            rresp,
   input  logic                  rvalid,
   output logic                  rready,
   // AXI write
   output logic [ADDR_WIDTH-1:0] awaddr,
   output logic [2:0]            awprot,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [31:0]           wdata,
   output logic [3:0]            wstrb,
   output logic                  wvalid,
   input  logic                  wready,
   input  logic [1:0]            bresp,
   input  logic                  bvalid,
   output logic                  bready
);

   typedef enum logic [2:0] {
      StIdle, StRdAddr, StRdData, StWrReq, StWrResp, StResp
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [3:0]              wstrb_q, wstrb_d;
   logic                    arvalid_q, arvalid_d;
   logic                    rready_q, rready_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    bready_q, bready_d;
   logic                    resp_valid_q, resp_valid_d;
   logic                    resp_err_q, resp_err_d;
   logic [31:0]             resp_rdata_q, resp_rdata_d;
   logic                    misaligned;
   logic                    aw_done, w_done;

`ifdef AXI_MASTER_ALIGN_CHECK_EN
   assign misaligned = (req_addr[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // A channel counts as done once its valid has dropped or is handshaking now.
   assign aw_done = !awvalid_q || awready;
   assign w_done  = !wvalid_q || wready;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      awvalid_d    = awvalid_q;
      wvalid_d     = wvalid_q;
      bready_d     = bready_q;
      resp_valid_d = resp_valid_q;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               wstrb_d = req_wstrb;
               if (misaligned) begin
                  state_d      = StResp;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'h0;
               end else if (req_write) begin
                  state_d   = StWrReq;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = StRdAddr;
                  arvalid_d = 1'b1;
               end
            end
         end
         StRdAddr: begin
            if (arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = StRdData;
            end
         end
         StRdData: begin
            if (rvalid) begin
               rready_d     = 1'b0;
               resp_rdata_d = rdata;
               resp_err_d   = (rresp != 2'b00);
               resp_valid_d = 1'b1;
               state_d      = StResp;
            end
         end
         StWrReq: begin
            if (awready) awvalid_d = 1'b0;
            if (wready)  wvalid_d  = 1'b0;
            if (aw_done && w_done) begin
               bready_d = 1'b1;
               state_d  = StWrResp;
            end
         end
         StWrResp: begin
            if (bvalid) begin
               bready_d     = 1'b0;
               resp_rdata_d = 32'h0;
               resp_err_d   = (bresp != 2'b00);
               resp_valid_d = 1'b1;
               state_d      = StResp;
            end
         end
         StResp: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         wdata_q      <= 32'h0;
         wstrb_q      <= 4'h0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         awvalid_q    <= awvalid_d;
         wvalid_q     <= wvalid_d;
         bready_q     <= bready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign req_ready  = (state_q == StIdle);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign araddr     = addr_q;
   assign arprot     = 3'b000;
   assign arvalid    = arvalid_q;
   assign rready     = rready_q;
   assign awaddr     = addr_q;
   assign awprot     = 3'b000;
   assign awvalid    = awvalid_q;
   assign wdata      = wdata_q;
   assign wstrb      = wstrb_q;
   assign wvalid     = wvalid_q;
   assign bready     = bready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: directed vector table, reset-in-flight sequence and random traffic
// against a cycle-count reference model; honours AXI_MASTER_ALIGN_CHECK_EN.
module tb_axi_lite_master;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] araddr, awaddr, rdata, wdata;
   logic [2:0]  arprot, awprot;
   logic        arvalid, arready, rvalid, rready;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [1:0]  rresp, bresp;
   logic [3:0]  wstrb;

   int checks = 0;
   int failures = 0;

   always #5 aclk = ~aclk;

   axi_lite_master #(.ADDR_WIDTH(32)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   typedef struct {
      bit          write;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  ws;
      int          ar_dly, r_dly, aw_dly, w_dly, b_dly, hold;
      logic [31:0] rd;
      logic [1:0]  rr, br;
      logic [31:0] exp_rdata;
      bit          exp_err;
      int          exp_lat;
   } vec_t;

`ifdef AXI_MASTER_ALIGN_CHECK_EN
   localparam bit AlignEn = 1'b1;
`else
   localparam bit AlignEn = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference outcome of one transaction, from the protocol rules alone.
   function automatic void predict(input vec_t v, output logic [31:0] rd, output bit err,
                                   output int lat, output int n_ar, output int n_aw,
                                   output int rr_cyc, output int br_cyc);
      bit mis;
      mis = AlignEn && (v.addr[1:0] != 2'b00);
      n_ar = 0; n_aw = 0; rr_cyc = 0; br_cyc = 0;
      if (mis) begin
         rd = 0; err = 1; lat = 1;
      end else if (v.write) begin
         rd = 0; err = (v.br != 0);
         lat = 3 + ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + v.b_dly;
         n_aw = 1; br_cyc = v.b_dly + 1;
      end else begin
         rd = v.rd; err = (v.rr != 0);
         lat = 3 + v.ar_dly + v.r_dly;
         n_ar = 1; rr_cyc = v.r_dly + 1;
      end
   endfunction

   task automatic drive_idle_slave();
      arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
   endtask

   // Runs one transaction; called and returns at posedge+1.
   task automatic run_txn(input string tag, input vec_t v, input bit stray);
      logic [31:0] e_rd, got_rd;
      bit          e_err, got_err, done;
      int e_lat, e_nar, e_naw, e_rr, e_br;
      int k, acc, ar_first, ar_hs, aw_first, aw_hs, w_first, w_hs, resp_first;
      int n_ar, n_aw, n_w, n_r, n_b, rr_cyc, br_cyc, viol, m;
      predict(v, e_rd, e_err, e_lat, e_nar, e_naw, e_rr, e_br);
      acc = -1; ar_first = -1; ar_hs = -1; aw_first = -1; aw_hs = -1; w_first = -1;
      w_hs = -1; resp_first = -1; n_ar = 0; n_aw = 0; n_w = 0; n_r = 0; n_b = 0;
      rr_cyc = 0; br_cyc = 0; viol = 0; done = 0; k = 0; got_rd = 0; got_err = 0;
      req_valid = 1; req_write = v.write; req_addr = v.addr; req_wdata = v.wd;
      req_wstrb = v.ws; resp_ready = 0;
      while (!done && k < 400) begin
         if (acc < 0 && req_ready) acc = k;
         if (acc >= 0 && k > acc && req_ready) viol++;
         if (arprot != 0 || awprot != 0) viol++;
         drive_idle_slave();
         if (arvalid) begin
            if (araddr !== v.addr) viol++;
            if (ar_first < 0) ar_first = k;
            if (k - ar_first >= v.ar_dly) begin arready = 1; ar_hs = k; n_ar++; end
         end
         if (awvalid) begin
            if (awaddr !== v.addr) viol++;
            if (aw_first < 0) aw_first = k;
            if (k - aw_first >= v.aw_dly) begin awready = 1; aw_hs = k; n_aw++; end
         end
         if (wvalid) begin
            if (wdata !== v.wd || wstrb !== v.ws) viol++;
            if (w_first < 0) w_first = k;
            if (k - w_first >= v.w_dly) begin wready = 1; w_hs = k; n_w++; end
         end
         if (ar_hs >= 0 && k > ar_hs && n_r == 0) begin
            if (k - ar_hs - 1 >= v.r_dly) begin
               rvalid = 1; rdata = v.rd; rresp = v.rr;
               if (rready) n_r++;
            end
         end else if (stray) begin
            rvalid = 1'($urandom); rdata = $urandom; rresp = 2'($urandom);
         end
         m = (aw_hs > w_hs) ? aw_hs : w_hs;
         if (aw_hs >= 0 && w_hs >= 0 && k > m && n_b == 0) begin
            if (k - m - 1 >= v.b_dly) begin
               bvalid = 1; bresp = v.br;
               if (bready) n_b++;
            end
         end else if (stray) begin
            bvalid = 1'($urandom); bresp = 2'($urandom);
         end
         if (rready) rr_cyc++;
         if (bready) begin
            br_cyc++;
            if (awvalid || wvalid) viol++;
         end
         if (resp_valid) begin
            if (resp_first < 0) begin
               resp_first = k; got_rd = resp_rdata; got_err = resp_err;
            end else if (resp_rdata !== got_rd || resp_err !== got_err) viol++;
            if (k - resp_first >= v.hold) begin resp_ready = 1; done = 1; end
         end
         @(posedge aclk); #1;
         k++;
         if (acc >= 0) req_valid = 0;
      end
      req_valid = 0; resp_ready = 0;
      drive_idle_slave();
      chk({tag, " done"}, 32'(done), 1);
      chk({tag, " rdata"}, got_rd, e_rd);
      chk({tag, " err"}, 32'(got_err), 32'(e_err));
      chk({tag, " latency"}, resp_first - acc, e_lat);
      chk({tag, " ar_hs"}, n_ar, e_nar);
      chk({tag, " aw_hs"}, n_aw, e_naw);
      chk({tag, " w_hs"}, n_w, e_naw);
      chk({tag, " aw_w_same_start"}, aw_first, (e_naw != 0) ? acc + 1 : -1);
      chk({tag, " rready_cycles"}, rr_cyc, e_rr);
      chk({tag, " bready_cycles"}, br_cyc, e_br);
      chk({tag, " protocol"}, viol, 0);
      chk({tag, " req_ready_after"}, 32'(req_ready), 1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " arvalid"}, 32'(arvalid), 0);
      chk({tag, " rready"}, 32'(rready), 0);
      chk({tag, " awvalid"}, 32'(awvalid), 0);
      chk({tag, " wvalid"}, 32'(wvalid), 0);
      chk({tag, " bready"}, 32'(bready), 0);
      chk({tag, " resp_valid"}, 32'(resp_valid), 0);
      chk({tag, " resp_err"}, 32'(resp_err), 0);
      chk({tag, " resp_rdata"}, resp_rdata, 0);
      chk({tag, " araddr"}, araddr, 0);
      chk({tag, " awaddr"}, awaddr, 0);
      chk({tag, " wdata"}, wdata, 0);
      chk({tag, " wstrb"}, 32'(wstrb), 0);
   endtask

   initial begin
      vec_t tbl[7];
      vec_t v;
      logic [31:0] prd;
      bit          perr;
      int          plat, p1, p2, p3, p4;

      // write addr wdata wstrb ar r aw w b hold rdata rresp bresp exp_rdata exp_err exp_lat
      tbl[0] = '{0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 2'b00, 2'b00,
                 32'hDEADBEEF, 0, 3};
      tbl[1] = '{1, 32'h20, 32'h12345678, 4'hF, 0, 0, 0, 2, 0, 0, 32'h0, 2'b00, 2'b00,
                 32'h0, 0, 5};
      tbl[2] = '{0, 32'h30, 32'h0, 4'h0, 0, 30, 0, 0, 0, 0, 32'hBAD0BAD0, 2'b10, 2'b00,
                 32'hBAD0BAD0, 1, 33};
      tbl[3] = '{0, 32'h44, 32'h0, 4'h0, 0, 0, 0, 0, 0, 5, 32'hCAFEF00D, 2'b00, 2'b00,
                 32'hCAFEF00D, 0, 3};
      tbl[4] = '{1, 32'h48, 32'hA5A5A5A5, 4'h3, 0, 0, 3, 1, 2, 1, 32'h0, 2'b00, 2'b11,
                 32'h0, 1, 8};
`ifdef AXI_MASTER_ALIGN_CHECK_EN
      tbl[5] = '{0, 32'h13, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h11112222, 2'b00, 2'b00,
                 32'h0, 1, 1};
      tbl[6] = '{1, 32'h22, 32'h55AA55AA, 4'hC, 0, 0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b00,
                 32'h0, 1, 1};
`else
      tbl[5] = '{0, 32'h13, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h11112222, 2'b00, 2'b00,
                 32'h11112222, 0, 3};
      tbl[6] = '{1, 32'h22, 32'h55AA55AA, 4'hC, 0, 0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b00,
                 32'h0, 0, 3};
`endif

      aresetn = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
      resp_ready = 0;
      drive_idle_slave();
      #12;
      chk_reset_outputs("reset");
      chk("reset req_ready", 32'(req_ready), 1);
      @(negedge aclk); aresetn = 1;
      @(posedge aclk); #1;

      // Table: constants in the table are cross-checked against the model too.
      foreach (tbl[i]) begin
         predict(tbl[i], prd, perr, plat, p1, p2, p3, p4);
         chk($sformatf("tbl%0d model_rdata", i), prd, tbl[i].exp_rdata);
         chk($sformatf("tbl%0d model_lat", i), plat, tbl[i].exp_lat);
         run_txn($sformatf("tbl%0d", i), tbl[i], 1'b0);
      end

      // Reset asserted while in WR_REQ with both AW and W stalled.
      req_valid = 1; req_write = 1; req_addr = 32'h40; req_wdata = 32'h0BADF00D;
      req_wstrb = 4'hF;
      @(posedge aclk); #1;
      req_valid = 0;
      chk("rst_mid pre awvalid", 32'(awvalid), 1);
      chk("rst_mid pre wvalid", 32'(wvalid), 1);
      aresetn = 0;
      #1;
      chk_reset_outputs("rst_mid");
      @(negedge aclk); aresetn = 1;
      @(posedge aclk); #1;
      chk("rst_mid req_ready", 32'(req_ready), 1);
      chk("rst_mid awvalid after", 32'(awvalid), 0);
      run_txn("post_rst", tbl[0], 1'b0);

      for (int i = 0; i < 40; i++) begin
         v.write = 1'($urandom);
         v.addr = $urandom;
         if ($urandom_range(0, 3) != 0) v.addr[1:0] = 2'b00;
         v.wd = $urandom; v.ws = 4'($urandom);
         v.ar_dly = $urandom_range(0, 4); v.r_dly = $urandom_range(0, 4);
         v.aw_dly = $urandom_range(0, 4); v.w_dly = $urandom_range(0, 4);
         v.b_dly = $urandom_range(0, 4); v.hold = $urandom_range(0, 3);
         v.rd = $urandom; v.rr = 2'($urandom); v.br = 2'($urandom);
         v.exp_rdata = 0; v.exp_err = 0; v.exp_lat = 0;
         run_txn($sformatf("rnd%0d", i), v, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
